// File: rtl/conv_bram_1d_ctrl_if.sv
// Control/status bundle between the 1-D convolution controller and its image BRAM and datapath.
// Optional cycle_count member exists only when CONV_1D_CTRL_PERF_EN is defined.
interface conv_bram_1d_ctrl_if #(
    parameter int IMG_RAM_ADDR_WIDTH    = 5,
    parameter int RESULT_RAM_ADDR_WIDTH = 5
);
    logic                             start;
    logic                             busy;
    logic                             done;
    logic                             img_rden;
    logic [IMG_RAM_ADDR_WIDTH-1:0]    img_rdaddr;
    logic                             dpath_sr_wren;
    logic [RESULT_RAM_ADDR_WIDTH-1:0] dpath_result_wraddr;
    logic                             dpath_result_wren;
    logic                             last_val;
`ifdef CONV_1D_CTRL_PERF_EN
    logic [31:0]                      cycle_count;

    modport master (
        input  start, last_val,
        output busy, done, img_rden, img_rdaddr, dpath_sr_wren,
               dpath_result_wraddr, dpath_result_wren, cycle_count
    );
    modport slave (
        output start, last_val,
        input  busy, done, img_rden, img_rdaddr, dpath_sr_wren,
               dpath_result_wraddr, dpath_result_wren, cycle_count
    );
`else
    modport master (
        input  start, last_val,
        output busy, done, img_rden, img_rdaddr, dpath_sr_wren,
               dpath_result_wraddr, dpath_result_wren
    );
    modport slave (
        output start, last_val,
        input  busy, done, img_rden, img_rdaddr, dpath_sr_wren,
               dpath_result_wraddr, dpath_result_wren
    );
`endif
endinterface

// File: rtl/conv_bram_1d_ctrl.sv
// Control FSM for the 1-D BRAM convolution engine; all outputs registered, first read 1 cycle after start.
// No backpressure: streams one column per cycle, then waits for last_val. CONV_1D_CTRL_PERF_EN adds cycle_count.
module conv_bram_1d_ctrl #(
    parameter int IMG_W    = 32,
    parameter int FILTER_L = 3,
    parameter int STRIDE_W = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    conv_bram_1d_ctrl_if.master   bus
);
    localparam int RESULT_W  = (IMG_W - FILTER_L) / STRIDE_W + 1;
    localparam int LAST_ADDR = FILTER_L - 1 + (RESULT_W - 1) * STRIDE_W;
    localparam int IA_W      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RA_W      = (RESULT_W > 1) ? $clog2(RESULT_W) : 1;
    localparam int KW        = $clog2(FILTER_L + 1);
    localparam int SW        = (STRIDE_W > 1) ? $clog2(STRIDE_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rden_q, rden_d;
    logic [IA_W-1:0]   rdaddr_q, rdaddr_d;
    logic              sr_wren_q, sr_wren_d;
    logic              res_wren_q, res_wren_d;
    logic [RA_W-1:0]   res_addr_q, res_addr_d;
    logic [RA_W-1:0]   idx_q, idx_d;
    logic [KW-1:0]     k_q, k_d;
    logic [SW-1:0]     s_q, s_d;
    logic              win_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rden_q     <= 1'b0;
            rdaddr_q   <= '0;
            sr_wren_q  <= 1'b0;
            res_wren_q <= 1'b0;
            res_addr_q <= '0;
            idx_q      <= '0;
            k_q        <= '0;
            s_q        <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rden_q     <= rden_d;
            rdaddr_q   <= rdaddr_d;
            sr_wren_q  <= sr_wren_d;
            res_wren_q <= res_wren_d;
            res_addr_q <= res_addr_d;
            idx_q      <= idx_d;
            k_q        <= k_d;
            s_q        <= s_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rden_d     = rden_q;
        rdaddr_d   = rdaddr_q;
        sr_wren_d  = rden_q;
        res_wren_d = 1'b0;
        res_addr_d = res_addr_q;
        idx_d      = idx_q;
        k_d        = k_q;
        s_d        = s_q;
        win_done   = 1'b0;

        // k saturates at FILTER_L; from then on the stride counter alone marks windows
        if (sr_wren_q) begin
            if (k_q != KW'(FILTER_L)) begin
                k_d = k_q + 1'b1;
            end
            if (k_q == KW'(FILTER_L - 1)) begin
                win_done = 1'b1;
                s_d      = SW'(STRIDE_W - 1);
            end else if (k_q == KW'(FILTER_L)) begin
                if (s_q == '0) begin
                    win_done = 1'b1;
                    s_d      = SW'(STRIDE_W - 1);
                end else begin
                    s_d = s_q - 1'b1;
                end
            end
        end
        if (win_done) begin
            res_wren_d = 1'b1;
            res_addr_d = idx_q;
            idx_d      = idx_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_LOAD;
                    busy_d   = 1'b1;
                    rden_d   = 1'b1;
                    rdaddr_d = '0;
                    k_d      = '0;
                    s_d      = '0;
                    idx_d    = '0;
                end
            end
            S_LOAD: begin
                if (rdaddr_q == IA_W'(LAST_ADDR)) begin
                    rden_d  = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    rdaddr_d = rdaddr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // last_val only counts once the shift and result pipelines are empty
                if (bus.last_val && !sr_wren_q && !res_wren_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CONV_1D_CTRL_PERF_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        // the accepting cycle is counted as the first cycle of the run
        if (state_q == S_IDLE && bus.start) begin
            cnt_d = 32'd1;
        end else if (busy_q && cnt_q != '1) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.cycle_count = cnt_q;
`endif

    assign bus.busy                = busy_q;
    assign bus.done                = done_q;
    assign bus.img_rden            = rden_q;
    assign bus.img_rdaddr          = rdaddr_q;
    assign bus.dpath_sr_wren       = sr_wren_q;
    assign bus.dpath_result_wraddr = res_addr_q;
    assign bus.dpath_result_wren   = res_wren_q;
endmodule

// File: tb/tb_conv_bram_1d_ctrl.sv
// Bench for conv_bram_1d_ctrl: three parameter sets (8/3/1, 8/3/2, 4/4/1) driven with directed runs.
// Per-cycle expectations come from the cycle numbering of a run (start sampled in cycle 0).
module tb_conv_bram_1d_ctrl;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    logic       start_a [3];
    logic       lv_a    [3];
    logic       busy_a  [3];
    logic       done_a  [3];
    logic       rden_a  [3];
    logic [7:0] addr_a  [3];
    logic       sr_a    [3];
    logic       rw_a    [3];
    logic [7:0] ra_a    [3];

    conv_bram_1d_ctrl_if #(.IMG_RAM_ADDR_WIDTH(3), .RESULT_RAM_ADDR_WIDTH(3)) if0 ();
    conv_bram_1d_ctrl_if #(.IMG_RAM_ADDR_WIDTH(3), .RESULT_RAM_ADDR_WIDTH(2)) if1 ();
    conv_bram_1d_ctrl_if #(.IMG_RAM_ADDR_WIDTH(2), .RESULT_RAM_ADDR_WIDTH(1)) if2 ();

    conv_bram_1d_ctrl #(.IMG_W(8), .FILTER_L(3), .STRIDE_W(1)) u_dut0 (.clk(clk), .reset(reset), .bus(if0.master));
    conv_bram_1d_ctrl #(.IMG_W(8), .FILTER_L(3), .STRIDE_W(2)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.master));
    conv_bram_1d_ctrl #(.IMG_W(4), .FILTER_L(4), .STRIDE_W(1)) u_dut2 (.clk(clk), .reset(reset), .bus(if2.master));

    assign if0.start = start_a[0];
    assign if1.start = start_a[1];
    assign if2.start = start_a[2];
    assign if0.last_val = lv_a[0];
    assign if1.last_val = lv_a[1];
    assign if2.last_val = lv_a[2];

    assign busy_a[0] = if0.busy;  assign busy_a[1] = if1.busy;  assign busy_a[2] = if2.busy;
    assign done_a[0] = if0.done;  assign done_a[1] = if1.done;  assign done_a[2] = if2.done;
    assign rden_a[0] = if0.img_rden;  assign rden_a[1] = if1.img_rden;  assign rden_a[2] = if2.img_rden;
    assign addr_a[0] = 8'(if0.img_rdaddr);
    assign addr_a[1] = 8'(if1.img_rdaddr);
    assign addr_a[2] = 8'(if2.img_rdaddr);
    assign sr_a[0] = if0.dpath_sr_wren;  assign sr_a[1] = if1.dpath_sr_wren;  assign sr_a[2] = if2.dpath_sr_wren;
    assign rw_a[0] = if0.dpath_result_wren;
    assign rw_a[1] = if1.dpath_result_wren;
    assign rw_a[2] = if2.dpath_result_wren;
    assign ra_a[0] = 8'(if0.dpath_result_wraddr);
    assign ra_a[1] = 8'(if1.dpath_result_wraddr);
    assign ra_a[2] = 8'(if2.dpath_result_wraddr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input int id, input string pfx);
        chk($sformatf("%s%0d_busy", pfx, id), int'(busy_a[id]), 0);
        chk($sformatf("%s%0d_done", pfx, id), int'(done_a[id]), 0);
        chk($sformatf("%s%0d_rden", pfx, id), int'(rden_a[id]), 0);
        chk($sformatf("%s%0d_addr", pfx, id), int'(addr_a[id]), 0);
        chk($sformatf("%s%0d_sr",   pfx, id), int'(sr_a[id]), 0);
        chk($sformatf("%s%0d_rw",   pfx, id), int'(rw_a[id]), 0);
        chk($sformatf("%s%0d_ra",   pfx, id), int'(ra_a[id]), 0);
    endtask

    // One run: start in cycle 0, last_val in cycle lv, checks through cycle ncyc.
    task automatic run_cfg(input int id, input int last_a, input int filt, input int strd,
                           input int lv, input int ncyc, input bit glitch, input bit b2b);
        int  n;
        bit  exp_rw;
        if (glitch) begin
            @(posedge clk); #1;
            lv_a[id] = 1'b1;
            @(negedge clk);
            chk($sformatf("cfg%0d_idle_lv_done", id), int'(done_a[id]), 0);
            chk($sformatf("cfg%0d_idle_lv_busy", id), int'(busy_a[id]), 0);
        end
        @(posedge clk); #1;
        lv_a[id]    = 1'b0;
        start_a[id] = 1'b1;
        @(posedge clk); #1;
        start_a[id] = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            lv_a[id]    = (c == lv) || (glitch && c == 3);
            start_a[id] = (glitch && c == 4) || (b2b && c == lv + 1);
            @(negedge clk);
            chk($sformatf("cfg%0d_c%0d_busy", id, c), int'(busy_a[id]), int'(c <= lv));
            chk($sformatf("cfg%0d_c%0d_done", id, c), int'(done_a[id]), int'(c == lv + 1));
            chk($sformatf("cfg%0d_c%0d_rden", id, c), int'(rden_a[id]), int'(c >= 1 && c <= last_a + 1));
            if (c <= last_a + 1)
                chk($sformatf("cfg%0d_c%0d_addr", id, c), int'(addr_a[id]), c - 1);
            chk($sformatf("cfg%0d_c%0d_sr", id, c), int'(sr_a[id]), int'(c >= 2 && c <= last_a + 2));
            n      = c - 2;
            exp_rw = (n >= filt) && (n <= last_a + 1) && ((n - filt) % strd == 0);
            chk($sformatf("cfg%0d_c%0d_rw", id, c), int'(rw_a[id]), int'(exp_rw));
            if (exp_rw)
                chk($sformatf("cfg%0d_c%0d_ra", id, c), int'(ra_a[id]), (n - filt) / strd);
`ifdef CONV_1D_CTRL_PERF_EN
            if (id == 0 && c == lv + 1)
                chk($sformatf("cfg0_c%0d_cycle_count", c), int'(if0.cycle_count), 15);
`endif
            @(posedge clk); #1;
        end
        lv_a[id] = 1'b0;
        if (b2b) begin
            start_a[id] = 1'b0;
            @(negedge clk);
            chk($sformatf("cfg%0d_b2b_busy", id), int'(busy_a[id]), 1);
            chk($sformatf("cfg%0d_b2b_rden", id), int'(rden_a[id]), 1);
            chk($sformatf("cfg%0d_b2b_addr", id), int'(addr_a[id]), 0);
        end else begin
            start_a[id] = 1'b0;
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'b0;
            lv_a[i]    = 1'b0;
        end
        #2;
        for (int i = 0; i < 3; i++) chk_idle_outputs(i, "rst");
        @(posedge clk); #1;
        reset = 1'b1;

        // 8/3/1 with stray last_val in IDLE/LOAD and stray start in LOAD
        run_cfg(0, 7, 3, 1, 14, 16, 1'b1, 1'b0);
`ifdef CONV_1D_CTRL_PERF_EN
        repeat (3) @(negedge clk);
        chk("cfg0_cycle_count_hold", int'(if0.cycle_count), 15);
`endif
        // 8/3/2: reads 0..6, strobes in cycles 5,7,9
        run_cfg(1, 6, 3, 2, 12, 14, 1'b0, 1'b0);
        // 4/4/1: single strobe in cycle 6, start held through done for a back-to-back run
        run_cfg(2, 3, 4, 1, 9, 10, 1'b0, 1'b1);

        // Mid-run asynchronous reset on 8/3/1 (cfg 4/4/1 is also mid-run here)
        @(posedge clk); #1;
        start_a[0] = 1'b1;
        @(posedge clk); #1;
        start_a[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rstmid_pre_busy", int'(busy_a[0]), 1);
        chk("rstmid_pre_addr", int'(addr_a[0]), 3);
        reset = 1'b0;
        #1;
        chk_idle_outputs(0, "rstmid");
        chk_idle_outputs(2, "rstmid");
        @(posedge clk); #1;
        reset = 1'b1;

        // Restart after abort begins again from address 0
        run_cfg(0, 7, 3, 1, 12, 13, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_bram_1d_ctrl.md
# conv_bram_1d_ctrl

Control FSM for the 1-D BRAM convolution engine. On `start` it streams the image BRAM column by column, drives the shift-register write enable of the datapath one cycle behind each read, and issues one result-write strobe with its result address for every complete, stride-aligned window. It then waits for the datapath's `last_val` before pulsing `done`, so it sits directly upstream of the 1-D convolution datapath and closes the loop on its completion flag.

## Interface
- `IMG_W`, 32: image width in columns.
- `FILTER_L`, 3: filter length in columns; must satisfy `FILTER_L <= IMG_W`.
- `STRIDE_W`, 1: window stride in columns; must be >= 1.
- `RESULT_W`, (IMG_W-FILTER_L)/STRIDE_W+1: derived; number of output columns.
- `LAST_ADDR`, FILTER_L-1+(RESULT_W-1)*STRIDE_W: derived; last image column read.
- `IMG_RAM_ADDR_WIDTH`, $clog2(IMG_W): derived.
- `RESULT_RAM_ADDR_WIDTH`, $clog2(RESULT_W): derived.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: reset is asynchronous and active-low.
- `start`, in, 1: run request; sampled only in IDLE.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at end of run.
- `img_rden`, out, IMG_RAM_ADDR_WIDTH→1: image BRAM read enable (1 bit).
- `img_rdaddr`, out, IMG_RAM_ADDR_WIDTH: image BRAM read address.
- `dpath_sr_wren`, out, 1: datapath shift-register enable.
- `dpath_result_wraddr`, out, RESULT_RAM_ADDR_WIDTH: result address sent into the datapath chain.
- `dpath_result_wren`, out, 1: result-valid strobe sent into the datapath chain.
- `last_val`, in, 1: datapath's final-result-written flag.

## Operation
- States: IDLE, LOAD, DRAIN. All outputs are registered.
- IDLE: on `start`=1, go to LOAD and clear all counters. Otherwise hold.
- LOAD:
  - Assert `img_rden` with `img_rdaddr` incrementing 0..LAST_ADDR, one address per cycle.
  - After the cycle with `img_rdaddr`=LAST_ADDR, go to DRAIN.
  - Columns after LAST_ADDR are never read.
- `dpath_sr_wren` is `img_rden` delayed by one cycle, matching the 1-cycle BRAM read latency.
- Window detection: a loaded-column counter k (1-based) advances on each `dpath_sr_wren`. A stride counter is reloaded to STRIDE_W-1 when k reaches FILTER_L and decrements per load thereafter. A window is complete when k>=FILTER_L and the stride counter is at 0 (reload point). No modulo logic.
- On a window-complete load, assert `dpath_result_wren` on the next cycle with `dpath_result_wraddr`=window index (0..RESULT_W-1). The index increments after each strobe and never wraps within a run.
- DRAIN:
  - Finish any pending `dpath_sr_wren` and `dpath_result_wren`.
  - Then wait for `last_val`=1. In the cycle after it is sampled, pulse `done` for one cycle and return to IDLE.
- `last_val` is ignored outside DRAIN.
- `start` is ignored while `busy`.
- Reset mid-run aborts immediately to IDLE. In-flight datapath results are not tracked.

## Timing
- Reset values: `busy`, `done`, `img_rden`, `dpath_sr_wren`, `dpath_result_wren` are 0; `img_rdaddr` and `dpath_result_wraddr` are 0.
- With `start` sampled at cycle 0:
  - `img_rden` is high in cycles 1..LAST_ADDR+1.
  - `dpath_sr_wren` is high in cycles 2..LAST_ADDR+2.
- A window completed by the load in cycle c produces `dpath_result_wren` in cycle c+1. The first strobe is in cycle FILTER_L+2.
- `done` is high in cycle t+1, where t is the first DRAIN cycle with `last_val`=1. `busy` drops in the same cycle t+1.
- Back-to-back runs: `start` held high is accepted in the first IDLE cycle after `done`.
- `dpath_result_wraddr` holds its value when `dpath_result_wren`=0.

## Configuration
- `CONV_1D_CTRL_PERF_EN` defined:
  - Adds output `cycle_count` (32 bits, reset 0).
  - Cleared on start acceptance; increments every busy cycle; saturates at all-ones.
  - Holds its value after `done` until the next start.
- `CONV_1D_CTRL_PERF_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- IMG_W=8, FILTER_L=3, STRIDE_W=1, start at cycle 0:
  - Addresses 0..7 in cycles 1..8.
  - `dpath_sr_wren` in cycles 2..9.
  - `dpath_result_wren` in cycles 5..10, addresses 0..5.
  - `last_val` at cycle 14 → `done` at cycle 15.
- IMG_W=8, FILTER_L=3, STRIDE_W=2:
  - Reads stop at address 6 (cycle 7).
  - `dpath_result_wren` in cycles 5, 7, 9 with addresses 0, 1, 2.
  - Address 7 is never read.
- FILTER_L=IMG_W=4: one result strobe, address 0, in cycle 6. `done` follows `last_val` by 1 cycle.
- Pulse `start` during LOAD and pulse `last_val` in IDLE/LOAD → no restart, no early `done`.
- Assert `reset` low at cycle 4 of a run → all outputs 0 asynchronously. The next `start` restarts from address 0.
- With `CONV_1D_CTRL_PERF_EN`, config 1: `cycle_count`=15 when `done` is sampled and holds thereafter.
